aes128_enc_seq: RTL and testbench

- Sequencer that runs a full AES-128 block encryption on one shared aes64 round datapath.
- Issues the ks1/ks2/enc operation stream over the aes64 valid/ready interface.
- Expands the key on the fly, applies AddRoundKey, and returns the ciphertext.
- Sits between a memory-mapped crypto front end and a single aes64 instance.

---
 rtl/aes128_enc_seq.sv | 183 ++++++++++++++++++
 tb/tb_aes128_enc_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_enc_seq.sv
`default_nettype none
// ============================================================================
// Module  : aes128_enc_seq
// Brief   : AES-128 block encryption sequenced over one shared aes64 round
//           unit (ks1/ks2/enc ops), on-the-fly key expansion, ready watchdog.
// Revision: 1.0
// ============================================================================
module aes128_enc_seq #(
  parameter int TIMEOUT = 255
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] pt,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] ct,
  output logic         aes_valid,
  output logic         aes_mix,
  output logic         aes_op_enc,
  output logic         aes_op_dec,
  output logic         aes_op_imix,
  output logic         aes_op_ks1,
  output logic         aes_op_ks2,
  output logic [63:0]  aes_rs1,
  output logic [63:0]  aes_rs2,
  input  logic [63:0]  aes_rd,
  input  logic         aes_ready
);

  localparam int             WDW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] c_wdog_last = WDW'(TIMEOUT - 1);
  localparam logic [3:0]     c_last_rnd  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KS1  = 3'd1,
    S_KS2A = 3'd2,
    S_KS2B = 3'd3,
    S_ENC0 = 3'd4,
    S_ENC1 = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           r_state;
  logic [63:0]      r_s0, r_s1, r_k0, r_k1, r_t, r_n0;
  logic [3:0]       r_rnd;
  logic [WDW-1:0]   r_wdog;
  logic             w_fire;
  logic             w_wdog_hit;

  assign aes_op_dec  = 1'b0;
  assign aes_op_imix = 1'b0;

  always_comb begin
    aes_valid  = 1'b0;
    aes_mix    = 1'b0;
    aes_op_enc = 1'b0;
    aes_op_ks1 = 1'b0;
    aes_op_ks2 = 1'b0;
    aes_rs1    = '0;
    aes_rs2    = '0;
    case (r_state)
      S_KS1: begin
        aes_valid  = 1'b1;
        aes_op_ks1 = 1'b1;
        aes_rs1    = r_k1;
        aes_rs2    = {60'b0, r_rnd};
      end
      S_KS2A: begin
        aes_valid  = 1'b1;
        aes_op_ks2 = 1'b1;
        aes_rs1    = r_t;
        aes_rs2    = r_k0;
      end
      S_KS2B: begin
        aes_valid  = 1'b1;
        aes_op_ks2 = 1'b1;
        aes_rs1    = r_k0;
        aes_rs2    = r_k1;
      end
      // ENC1 swaps the halves so the unit produces the upper two columns
      S_ENC0, S_ENC1: begin
        aes_valid  = 1'b1;
        aes_op_enc = 1'b1;
        aes_mix    = (r_rnd != c_last_rnd);
        aes_rs1    = (r_state == S_ENC0) ? r_s0 : r_s1;
        aes_rs2    = (r_state == S_ENC0) ? r_s1 : r_s0;
      end
      default: ;
    endcase
  end

  assign w_fire     = aes_valid & aes_ready;
  assign w_wdog_hit = (TIMEOUT != 0) && aes_valid && !aes_ready && (r_wdog == c_wdog_last);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_state <= S_IDLE;
      r_s0    <= '0;
      r_s1    <= '0;
      r_k0    <= '0;
      r_k1    <= '0;
      r_t     <= '0;
      r_n0    <= '0;
      r_rnd   <= '0;
      r_wdog  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      ct      <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_s0    <= pt[63:0]   ^ key[63:0];
            r_s1    <= pt[127:64] ^ key[127:64];
            r_k0    <= key[63:0];
            r_k1    <= key[127:64];
            r_rnd   <= '0;
            r_wdog  <= '0;
            busy    <= 1'b1;
            r_state <= S_KS1;
          end
        end
        S_DONE: begin
          ct      <= {r_s1, r_s0};
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          if (w_wdog_hit) begin
            err     <= 1'b1;
            busy    <= 1'b0;
            r_wdog  <= '0;
            r_state <= S_IDLE;
          end else if (w_fire) begin
            r_wdog <= '0;
            case (r_state)
              S_KS1: begin
                r_t     <= aes_rd;
                r_state <= S_KS2A;
              end
              S_KS2A: begin
                r_k0    <= aes_rd;
                r_state <= S_KS2B;
              end
              S_KS2B: begin
                r_k1    <= aes_rd;
                r_state <= S_ENC0;
              end
              // the new low half waits in n0 because ENC1 still reads old s0
              S_ENC0: begin
                r_n0    <= aes_rd ^ r_k0;
                r_state <= S_ENC1;
              end
              S_ENC1: begin
                r_s1 <= aes_rd ^ r_k1;
                r_s0 <= r_n0;
                if (r_rnd == c_last_rnd) begin
                  r_state <= S_DONE;
                end else begin
                  r_rnd   <= r_rnd + 4'd1;
                  r_state <= S_KS1;
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes128_enc_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes128_enc_seq
// Brief   : Self-checking bench for aes128_enc_seq with an aes64 responder
//           model and a full-state AES-128 reference.
// Revision: 1.0
// ============================================================================
module tb_aes128_enc_seq;

  logic         clk = 1'b0;
  logic         g_resetn, start;
  logic [127:0] key, pt, ct;
  logic         busy, done, err;
  logic         aes_valid, aes_mix, aes_op_enc, aes_op_dec, aes_op_imix, aes_op_ks1, aes_op_ks2;
  logic [63:0]  aes_rs1, aes_rs2, aes_rd;
  logic         aes_ready;

  int           n_chk = 0;
  int           n_fail = 0;
  logic [7:0]   sbox [0:255];
  int           rmode = 0;
  logic         stall = 1'b0;
  logic         log_en = 1'b0;
  int           wl = 0;
  logic         rdy;
  logic         wait_prev = 1'b0;
  logic [159:0] snap_prev = '0;
  logic [67:0]  opq [$];

  always #5 clk = ~clk;

  aes128_enc_seq #(.TIMEOUT(4)) dut (
    .g_clk(clk), .g_resetn(g_resetn), .start(start), .key(key), .pt(pt),
    .busy(busy), .done(done), .err(err), .ct(ct),
    .aes_valid(aes_valid), .aes_mix(aes_mix), .aes_op_enc(aes_op_enc),
    .aes_op_dec(aes_op_dec), .aes_op_imix(aes_op_imix), .aes_op_ks1(aes_op_ks1),
    .aes_op_ks2(aes_op_ks2), .aes_rs1(aes_rs1), .aes_rs2(aes_rs2),
    .aes_rd(aes_rd), .aes_ready(aes_ready)
  );

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mixcol(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a3, a2, a1, a0} = w;
    return {xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3),
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3};
  endfunction

  function automatic logic [127:0] bswap(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = v[8*(15-i) +: 8];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Full-state textbook AES-128: expanded key schedule, then 10 rounds.
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [7:0]   w [0:175];
    logic [7:0]   s [0:15];
    logic [7:0]   t [0:15];
    logic [7:0]   tmp [0:3];
    logic [7:0]   rc;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) w[i] = k[8*i +: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
      if (i % 4 == 0) begin
        tmp[0] = sbox[w[4*(i-1)+1]] ^ rc;
        tmp[1] = sbox[w[4*(i-1)+2]];
        tmp[2] = sbox[w[4*(i-1)+3]];
        tmp[3] = sbox[w[4*(i-1)+0]];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = p[8*i +: 8] ^ w[i];
    for (int rn = 1; rn <= 10; rn++) begin
      for (int c = 0; c < 4; c++)
        for (int rw = 0; rw < 4; rw++) t[4*c+rw] = sbox[s[4*((c+rw)%4)+rw]];
      for (int c = 0; c < 4; c++) begin
        logic [31:0] col;
        col = {t[4*c+3], t[4*c+2], t[4*c+1], t[4*c]};
        if (rn != 10) col = mixcol(col);
        for (int rw = 0; rw < 4; rw++) s[4*c+rw] = col[8*rw +: 8] ^ w[16*rn+4*c+rw];
      end
    end
    for (int i = 0; i < 16; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  // Behaviour of the external aes64 unit for one op.
  function automatic logic [63:0] aes64_model(input logic ks1, input logic ks2, input logic enc,
                                              input logic mix, input logic [63:0] rs1,
                                              input logic [63:0] rs2);
    logic [31:0]  tw;
    logic [7:0]   rc;
    logic [127:0] st;
    logic [63:0]  r;
    r = '0;
    if (ks1) begin
      tw = rs1[63:32];
      if (rs2[3:0] != 4'hA) tw = {tw[7:0], tw[31:8]};
      for (int i = 0; i < 4; i++) tw[8*i +: 8] = sbox[tw[8*i +: 8]];
      rc = 8'h01;
      for (int i = 0; i < int'(rs2[3:0]); i++) rc = xt(rc);
      if (rs2[3:0] < 4'hA) tw[7:0] = tw[7:0] ^ rc;
      r = {tw, tw};
    end else if (ks2) begin
      r = {rs1[63:32] ^ rs2[31:0] ^ rs2[63:32], rs1[63:32] ^ rs2[31:0]};
    end else if (enc) begin
      st = {rs2, rs1};
      for (int b = 0; b < 8; b++) r[8*b +: 8] = sbox[st[8*(4*(((b/4)+(b%4))%4)+(b%4)) +: 8]];
      if (mix) r = {mixcol(r[63:32]), mixcol(r[31:0])};
    end
    return r;
  endfunction

  // aes64 responder: ready policy, result, operand-hold and one-hot checks.
  always @(negedge clk) begin
    logic [159:0] snap;
    snap = {26'b0, aes_op_enc, aes_op_dec, aes_op_imix, aes_op_ks1, aes_op_ks2, aes_mix, aes_rs1, aes_rs2};
    if (aes_valid && wait_prev) chk("hold", snap, snap_prev);
    if (aes_valid)
      chk("onehot", $countones({aes_op_enc, aes_op_dec, aes_op_imix, aes_op_ks1, aes_op_ks2}), 1);
    rdy = 1'b1;
    if (rmode == 1 && aes_valid) begin
      if (wl == 0) wl = $urandom_range(3, 0);
      else begin
        rdy = 1'b0;
        wl  = wl - 1;
      end
    end
    if (stall && aes_op_enc) rdy = 1'b0;
    aes_rd    = aes64_model(aes_op_ks1, aes_op_ks2, aes_op_enc, aes_mix, aes_rs1, aes_rs2);
    aes_ready = rdy;
    wait_prev = aes_valid && !rdy;
    snap_prev = snap;
    if (log_en && aes_valid && rdy)
      opq.push_back({aes_op_ks1, aes_op_ks2, aes_op_enc, aes_mix, aes_op_ks1 ? aes_rs2 : 64'b0});
  end

  task automatic run_enc(input logic [127:0] k, input logic [127:0] p, input int inj,
                         output int cyc, output logic [127:0] got, output logic saw_err);
    key = k; pt = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0; key = rand128(); pt = rand128();
    chk("busy_on", busy, 1);
    cyc = -1; saw_err = 1'b0; got = '0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (c == inj) begin
        chk("inj_in_ks2", aes_op_ks2, 1);
        start = 1'b1; key = rand128(); pt = rand128();
      end
      if (c == inj + 1) start = 1'b0;
      if (done || err) begin
        cyc = c; saw_err = err; got = ct;
        if (done) chk("busy_off", busy, 0);
        break;
      end
    end
    start = 1'b0;
    if (cyc < 0) chk("run_timeout", 0, 1);
  endtask

  initial begin
    logic [7:0]   p8, q8, x8;
    logic [127:0] k1, p1, c1, got, exp, prev_ct;
    int           cyc, d1, d2;
    logic         e, seen;

    p8 = 8'h01; q8 = 8'h01;
    do begin
      p8 = p8 ^ {p8[6:0], 1'b0} ^ (p8[7] ? 8'h1b : 8'h00);
      q8 = q8 ^ {q8[6:0], 1'b0};
      q8 = q8 ^ {q8[5:0], 2'b0};
      q8 = q8 ^ {q8[3:0], 4'b0};
      if (q8[7]) q8 = q8 ^ 8'h09;
      x8 = q8 ^ {q8[6:0], q8[7]} ^ {q8[5:0], q8[7:6]} ^ {q8[4:0], q8[7:5]} ^ {q8[3:0], q8[7:4]};
      sbox[p8] = x8 ^ 8'h63;
    end while (p8 != 8'h01);
    sbox[0] = 8'h63;

    g_resetn = 1'b0; start = 1'b0; key = '0; pt = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, done, err, aes_valid, aes_mix, aes_op_enc, aes_op_dec, aes_op_imix, aes_op_ks1, aes_op_ks2}, 0);
    chk("rst_ct", ct, 0);
    chk("rst_ops", {aes_rs1, aes_rs2}, 0);
    g_resetn = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 with ready tied high: latency and op stream
    k1 = bswap(128'h000102030405060708090a0b0c0d0e0f);
    p1 = bswap(128'h00112233445566778899aabbccddeeff);
    c1 = bswap(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    opq.delete(); log_en = 1'b1;
    run_enc(k1, p1, -1, cyc, got, e);
    log_en = 1'b0;
    chk("t1_lat", cyc, 51);
    chk("t1_ct", got, c1);
    chk("t1_err", e, 0);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_nops", opq.size(), 50);
    for (int i = 0; i < opq.size() && i < 50; i++) begin
      int ph, rn;
      ph = i % 5; rn = i / 5;
      chk("t1_op", opq[i], {ph == 0, ph == 1 || ph == 2, ph >= 3, ph >= 3 && rn != 9,
                            (ph == 0) ? 64'(rn) : 64'b0});
    end

    // start pulse during KS2B of op 13 is ignored
    run_enc(k1, p1, 12, cyc, got, e);
    chk("t3_ct", got, c1);
    chk("t3_lat", cyc, 51);

    // random ready stalls: FIPS-197 B and random vectors
    rmode = 1;
    run_enc(bswap(128'h2b7e151628aed2a6abf7158809cf4f3c), bswap(128'h3243f6a8885a308d313198a2e0370734),
            -1, cyc, got, e);
    chk("t2_ct", got, bswap(128'h3925841d02dc09fbdc118597196a0b32));
    for (int n = 0; n < 4; n++) begin
      k1 = rand128(); p1 = rand128(); exp = aes_ref(k1, p1);
      run_enc(k1, p1, -1, cyc, got, e);
      chk("t2_rand_ct", got, exp);
      chk("t2_rand_err", e, 0);
    end
    rmode = 0;

    // watchdog abort at the first ENC0
    prev_ct = ct;
    stall = 1'b1;
    run_enc(rand128(), rand128(), -1, cyc, got, e);
    stall = 1'b0;
    chk("t4_err", e, 1);
    chk("t4_lat", cyc, 7);
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_ct", got, prev_ct);
    @(negedge clk);
    chk("t4_err_pulse", err, 0);
    k1 = rand128(); p1 = rand128();
    run_enc(k1, p1, -1, cyc, got, e);
    chk("t4_after_ct", got, aes_ref(k1, p1));
    chk("t4_after_lat", cyc, 51);

    // reset mid-round-5
    key = rand128(); pt = rand128(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (27) @(negedge clk);
    chk("t5_midop", aes_valid, 1);
    g_resetn = 1'b0;
    @(negedge clk);
    chk("t5_rst_ctl", {busy, done, err, aes_valid, aes_mix, aes_op_enc, aes_op_dec, aes_op_imix, aes_op_ks1, aes_op_ks2}, 0);
    chk("t5_rst_ct", ct, 0);
    chk("t5_rst_ops", {aes_rs1, aes_rs2}, 0);
    g_resetn = 1'b1;
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done || err || busy) seen = 1'b1;
    end
    chk("t5_quiet", seen, 0);
    k1 = rand128(); p1 = rand128();
    run_enc(k1, p1, -1, cyc, got, e);
    chk("t5_ct", got, aes_ref(k1, p1));

    // back-to-back with start held high
    k1 = rand128(); p1 = rand128(); exp = aes_ref(k1, p1);
    key = k1; pt = p1; start = 1'b1;
    d1 = -1; d2 = -1;
    for (int c = 0; c < 400 && d2 < 0; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin
          d1 = c;
          chk("t6_ct1", ct, exp);
        end else begin
          d2 = c;
          start = 1'b0;
          chk("t6_ct2", ct, exp);
        end
      end
    end
    start = 1'b0;
    if (d2 < 0) chk("t6_timeout", 0, 1);
    chk("t6_gap", d2 - d1, 52);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
